// File: rtl/costas_pkg.sv
// Shared NCO constants: default widths, dither LFSR polynomial/seed, quadrant encoding,
// and the elaboration-time generator for the quarter-wave table contents.
package costas_pkg;

   localparam int          COSTAS_PHASE_W    = 32;
   localparam int          COSTAS_TABLE_BITS = 10;
   localparam int          COSTAS_AMP_W      = 16;

   localparam int          LFSR_W    = 16;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   localparam logic [1:0]  QUAD_COS_OFFSET = 2'd1;
   localparam int          QUAD_MIRROR_BIT = 0;
   localparam int          QUAD_NEG_BIT    = 1;

   localparam real         PI = 3.14159265358979323846;

   function automatic int rom_entry(input int k, input int table_bits, input int amp_w);
      real full_scale;
      real angle;
      full_scale = real'((1 << (amp_w - 1)) - 1);
      angle      = 2.0 * PI * (real'(k) + 0.5) / real'(1 << table_bits);
      return $rtoi(full_scale * $sin(angle) + 0.5);
   endfunction

endpackage

// File: rtl/costas_nco_if.sv
// NCO sample-strobe / control inputs and sin/cos/phase outputs.
// master drives the controls, slave is the oscillator.
interface costas_nco_if
   import costas_pkg::*;
#(
   parameter int PHASE_W = COSTAS_PHASE_W,
   parameter int AMP_W   = COSTAS_AMP_W
);
   logic                     valid;
   logic [PHASE_W-1:0]       freq_ctrl;
   logic                     sync_clr;
   logic signed [AMP_W-1:0]  sin_out;
   logic signed [AMP_W-1:0]  cos_out;
   logic [PHASE_W-1:0]       phase_out;
   logic                     out_valid;

   modport master (output valid, freq_ctrl, sync_clr,
                   input  sin_out, cos_out, phase_out, out_valid);
   modport slave  (input  valid, freq_ctrl, sync_clr,
                   output sin_out, cos_out, phase_out, out_valid);
endinterface

// File: rtl/nco_quarter_rom.sv
// nco_quarter_rom: quarter-wave sine table with independent sin/cos read ports, 1-clk registered read.
// No backpressure: both ports are read every clock.
module nco_quarter_rom
   import costas_pkg::*;
#(
   parameter int TABLE_BITS = COSTAS_TABLE_BITS,
   parameter int AMP_W      = COSTAS_AMP_W
) (
   input  logic                  clk,
   input  logic [TABLE_BITS-3:0] sin_addr,
   input  logic [TABLE_BITS-3:0] cos_addr,
   output logic [AMP_W-1:0]      sin_dat,
   output logic [AMP_W-1:0]      cos_dat
);
   localparam int DEPTH = 1 << (TABLE_BITS - 2);

   logic [AMP_W-1:0] rom [DEPTH];
   logic [AMP_W-1:0] sin_dat_q, sin_dat_d;
   logic [AMP_W-1:0] cos_dat_q, cos_dat_d;

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic [AMP_W-1:0] ENTRY = AMP_W'(rom_entry(k, TABLE_BITS, AMP_W));
      assign rom[k] = ENTRY;
   end

   always_comb begin
      sin_dat_d = rom[sin_addr];
      cos_dat_d = rom[cos_addr];
   end

   always_ff @(posedge clk) begin
      sin_dat_q <= sin_dat_d;
      cos_dat_q <= cos_dat_d;
   end

   assign sin_dat = sin_dat_q;
   assign cos_dat = cos_dat_q;
endmodule

// File: rtl/costas_nco.sv
// costas_nco: phase accumulator feeding a folded quarter-wave sin/cos lookup; 3-clk latency, 1 sample/clk.
// No backpressure (out_valid is valid delayed 3 clks); phase dither enabled by COSTAS_NCO_DITHER_EN.
module costas_nco
   import costas_pkg::*;
#(
   parameter int                 PHASE_W    = COSTAS_PHASE_W,
   parameter int                 TABLE_BITS = COSTAS_TABLE_BITS,
   parameter int                 AMP_W      = COSTAS_AMP_W,
   parameter logic [PHASE_W-1:0] INIT_PHASE = '0
) (
   input logic         clk,
   input logic         rst,
   costas_nco_if.slave nco
);
   localparam int ADDR_W = TABLE_BITS - 2;

   logic [PHASE_W-1:0]    acc_q, acc_d;
   logic                  s1_vld_q, s1_vld_d;
   logic [PHASE_W-1:0]    s1_phase_q, s1_phase_d;
   logic                  s2_vld_q, s2_vld_d;
   logic [PHASE_W-1:0]    s2_phase_q, s2_phase_d;
   logic                  s2_sin_neg_q, s2_sin_neg_d;
   logic                  s2_cos_neg_q, s2_cos_neg_d;
   logic                  out_vld_q, out_vld_d;
   logic [AMP_W-1:0]      sin_q, sin_d;
   logic [AMP_W-1:0]      cos_q, cos_d;
   logic [PHASE_W-1:0]    phase_q, phase_d;
   logic [TABLE_BITS-1:0] look_top;
   logic [1:0]            sin_quad, cos_quad;
   logic [ADDR_W-1:0]     frac, sin_addr, cos_addr;
   logic [AMP_W-1:0]      rom_sin, rom_cos;

`ifdef COSTAS_NCO_DITHER_EN
   localparam int DITHER_SH = PHASE_W - TABLE_BITS - LFSR_W;

   logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
   logic [TABLE_BITS-1:0] s1_look_q, s1_look_d;

   // Only the lookup sees the dither; phase_out keeps the clean accumulator value.
   always_comb begin
      lfsr_d    = lfsr_q;
      s1_look_d = s1_look_q;
      if (nco.valid) begin
         lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
         s1_look_d = TABLE_BITS'((acc_q + (PHASE_W'(lfsr_q) << DITHER_SH)) >> (PHASE_W - TABLE_BITS));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q    <= LFSR_SEED;
         s1_look_q <= '0;
      end else begin
         lfsr_q    <= lfsr_d;
         s1_look_q <= s1_look_d;
      end
   end

   assign look_top = s1_look_q;
`else
   assign look_top = s1_phase_q[PHASE_W-1 -: TABLE_BITS];
`endif

   // Quadrants 1 and 3 mirror the table address; 2 and 3 negate the result.
   always_comb begin
      sin_quad = look_top[TABLE_BITS-1 -: 2];
      cos_quad = sin_quad + QUAD_COS_OFFSET;
      frac     = look_top[ADDR_W-1:0];
      sin_addr = sin_quad[QUAD_MIRROR_BIT] ? ~frac : frac;
      cos_addr = cos_quad[QUAD_MIRROR_BIT] ? ~frac : frac;
   end

   nco_quarter_rom #(
      .TABLE_BITS (TABLE_BITS),
      .AMP_W      (AMP_W)
   ) u_rom (
      .clk      (clk),
      .sin_addr (sin_addr),
      .cos_addr (cos_addr),
      .sin_dat  (rom_sin),
      .cos_dat  (rom_cos)
   );

   always_comb begin
      acc_d        = acc_q;
      s1_vld_d     = nco.valid;
      s1_phase_d   = s1_phase_q;
      s2_vld_d     = s1_vld_q;
      s2_phase_d   = s1_phase_q;
      s2_sin_neg_d = sin_quad[QUAD_NEG_BIT];
      s2_cos_neg_d = cos_quad[QUAD_NEG_BIT];
      out_vld_d    = s2_vld_q;
      sin_d        = sin_q;
      cos_d        = cos_q;
      phase_d      = phase_q;
      if (nco.valid) begin
         s1_phase_d = acc_q;
         acc_d      = acc_q + nco.freq_ctrl;
      end
      if (nco.sync_clr) begin
         acc_d = INIT_PHASE;
      end
      if (s2_vld_q) begin
         sin_d   = s2_sin_neg_q ? AMP_W'(-rom_sin) : rom_sin;
         cos_d   = s2_cos_neg_q ? AMP_W'(-rom_cos) : rom_cos;
         phase_d = s2_phase_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q        <= INIT_PHASE;
         s1_vld_q     <= 1'b0;
         s1_phase_q   <= '0;
         s2_vld_q     <= 1'b0;
         s2_phase_q   <= '0;
         s2_sin_neg_q <= 1'b0;
         s2_cos_neg_q <= 1'b0;
         out_vld_q    <= 1'b0;
         sin_q        <= '0;
         cos_q        <= '0;
         phase_q      <= '0;
      end else begin
         acc_q        <= acc_d;
         s1_vld_q     <= s1_vld_d;
         s1_phase_q   <= s1_phase_d;
         s2_vld_q     <= s2_vld_d;
         s2_phase_q   <= s2_phase_d;
         s2_sin_neg_q <= s2_sin_neg_d;
         s2_cos_neg_q <= s2_cos_neg_d;
         out_vld_q    <= out_vld_d;
         sin_q        <= sin_d;
         cos_q        <= cos_d;
         phase_q      <= phase_d;
      end
   end

   assign nco.out_valid = out_vld_q;
   assign nco.sin_out   = sin_q;
   assign nco.cos_out   = cos_q;
   assign nco.phase_out = phase_q;
endmodule

// File: tb/tb_costas_nco.sv
// Directed-vector bench for costas_nco: table of per-cycle inputs with the outputs expected
// at that same cycle (3 clks after the matching input), plus wrap and reset-pulse sequences.
module tb_costas_nco;

   typedef struct {
      logic        v;
      logic [31:0] f;
      logic        clr;
      logic        ov;
      int          s;
      int          c;
      logic [31:0] ph;
   } vec_t;

   localparam int NV = 28;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t tbl [NV];

   costas_nco_if #(.PHASE_W(32), .AMP_W(16)) if0 ();
   costas_nco_if #(.PHASE_W(32), .AMP_W(16)) if1 ();

   costas_nco dut0 (.clk(clk), .rst(rst), .nco(if0));
   costas_nco #(.INIT_PHASE(32'hFFFF_FF00)) dut1 (.clk(clk), .rst(rst), .nco(if1));

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic [31:0] f, input logic clr,
                               input logic ov, input int s, input int c, input logic [31:0] ph);
      vec_t r;
      r.v = v; r.f = f; r.clr = clr; r.ov = ov; r.s = s; r.c = c; r.ph = ph;
      return r;
   endfunction

   task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic chk_out(input string tag, input bit sel, input logic eov,
                          input int es, input int ec, input logic [31:0] eph);
      logic               ov;
      logic signed [31:0] s, c;
      logic [31:0]        ph;
      if (sel) begin
         ov = if1.out_valid; s = $signed(if1.sin_out); c = $signed(if1.cos_out); ph = if1.phase_out;
      end else begin
         ov = if0.out_valid; s = $signed(if0.sin_out); c = $signed(if0.cos_out); ph = if0.phase_out;
      end
      chk({tag, ".out_valid"}, {31'b0, ov}, int'(eov));
      chk({tag, ".sin"}, s, es);
      chk({tag, ".cos"}, c, ec);
      chk({tag, ".phase"}, ph, int'(eph));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      if0.valid = 1'b0; if0.freq_ctrl = '0; if0.sync_clr = 1'b0;
      if1.valid = 1'b0; if1.freq_ctrl = '0; if1.sync_clr = 1'b0;

      // freq 0, then quadrant steps +90 deg, -90 deg, gapped valid, sync_clr mid-stream
      tbl[0]  = mk(1, 32'h0,         0, 0,      0,      0, 32'h0);
      tbl[1]  = mk(1, 32'h0,         0, 0,      0,      0, 32'h0);
      tbl[2]  = mk(1, 32'h0,         0, 0,      0,      0, 32'h0);
      tbl[3]  = mk(1, 32'h4000_0000, 0, 1,    101,  32767, 32'h0);
      tbl[4]  = mk(1, 32'h4000_0000, 0, 1,    101,  32767, 32'h0);
      tbl[5]  = mk(1, 32'h4000_0000, 0, 1,    101,  32767, 32'h0);
      tbl[6]  = mk(1, 32'h4000_0000, 0, 1,    101,  32767, 32'h0);
      tbl[7]  = mk(1, 32'hC000_0000, 0, 1,  32767,   -101, 32'h4000_0000);
      tbl[8]  = mk(1, 32'hC000_0000, 0, 1,   -101, -32767, 32'h8000_0000);
      tbl[9]  = mk(1, 32'hC000_0000, 0, 1, -32767,    101, 32'hC000_0000);
      tbl[10] = mk(1, 32'hC000_0000, 0, 1,    101,  32767, 32'h0);
      tbl[11] = mk(0, 32'h0,         0, 1, -32767,    101, 32'hC000_0000);
      tbl[12] = mk(0, 32'h0,         0, 1,   -101, -32767, 32'h8000_0000);
      tbl[13] = mk(1, 32'h1000_0000, 0, 1,  32767,   -101, 32'h4000_0000);
      tbl[14] = mk(0, 32'h0,         0, 0,  32767,   -101, 32'h4000_0000);
      tbl[15] = mk(1, 32'h3000_0000, 0, 0,  32767,   -101, 32'h4000_0000);
      tbl[16] = mk(0, 32'h0,         0, 1,    101,  32767, 32'h0);
      tbl[17] = mk(0, 32'h0,         0, 0,    101,  32767, 32'h0);
      tbl[18] = mk(0, 32'h0,         0, 1,  12632,  30234, 32'h1000_0000);
      tbl[19] = mk(0, 32'h0,         0, 0,  12632,  30234, 32'h1000_0000);
      tbl[20] = mk(0, 32'h0,         0, 0,  12632,  30234, 32'h1000_0000);
      tbl[21] = mk(1, 32'h4000_0000, 0, 0,  12632,  30234, 32'h1000_0000);
      tbl[22] = mk(1, 32'h4000_0000, 1, 0,  12632,  30234, 32'h1000_0000);
      tbl[23] = mk(1, 32'h4000_0000, 0, 0,  12632,  30234, 32'h1000_0000);
      tbl[24] = mk(0, 32'h0,         0, 1,  32767,   -101, 32'h4000_0000);
      tbl[25] = mk(0, 32'h0,         0, 1,   -101, -32767, 32'h8000_0000);
      tbl[26] = mk(0, 32'h0,         0, 1,    101,  32767, 32'h0);
      tbl[27] = mk(0, 32'h0,         0, 0,    101,  32767, 32'h0);

      repeat (3) @(negedge clk);
      chk_out("reset0", 1'b0, 1'b0, 0, 0, 32'h0);
      chk_out("reset1", 1'b1, 1'b0, 0, 0, 32'h0);
      rst = 1'b1;

      // accumulator wrap on the INIT_PHASE=FFFF_FF00 instance
      @(negedge clk); if1.valid = 1'b1; if1.freq_ctrl = 32'h100;
      @(negedge clk);
      @(negedge clk); if1.valid = 1'b0;
      @(negedge clk); chk_out("wrap0", 1'b1, 1'b1, -101, 32767, 32'hFFFF_FF00);
      @(negedge clk); chk_out("wrap1", 1'b1, 1'b1,  101, 32767, 32'h0000_0000);
      @(negedge clk); chk_out("wrap2", 1'b1, 1'b0,  101, 32767, 32'h0000_0000);

      for (int t = 0; t < NV; t++) begin
         @(negedge clk);
         chk_out($sformatf("row%0d", t), 1'b0, tbl[t].ov, tbl[t].s, tbl[t].c, tbl[t].ph);
         if0.valid = tbl[t].v; if0.freq_ctrl = tbl[t].f; if0.sync_clr = tbl[t].clr;
      end

      // reset pulse with samples in flight
      @(negedge clk); if0.valid = 1'b1; if0.freq_ctrl = 32'h0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); rst = 1'b0; if0.valid = 1'b0;
      #1;
      chk_out("rst_mid", 1'b0, 1'b0, 0, 0, 32'h0);
      @(negedge clk);
      chk("rst_hold.out_valid", {31'b0, if0.out_valid}, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("no_stale%0d.out_valid", i), {31'b0, if0.out_valid}, 0);
      end
      @(negedge clk); if0.valid = 1'b1; if0.freq_ctrl = 32'h1234_5678;
      @(negedge clk); if0.valid = 1'b0;
      @(negedge clk);
      @(negedge clk); chk_out("post_rst", 1'b0, 1'b1, 101, 32767, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
